// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the RAM data port between Core0 and a DMA/debug requester.
//   Round-robin grant with a bounded lock for bursts, one issue stage that
//   drives the RAM, one response stage that returns the RAM result to the
//   requester that owns it. Fixed latency: accept N, mem_enable N+1, rsp N+2.
// Ports
//   CLK, RESET            clock, synchronous active-high reset
//   core_req_* / dma_req_*  request valid/lock/memo/mask/addr/data, ready out
//   core_rsp_* / dma_rsp_*  one-cycle response pulse with data and exception
//   mem_enable, mem_*       RAM data-port drive (from the issue register)
//   mem_resp, mem_exc       RAM result, combinational in the mem_enable cycle
module mem_port_arbiter #(
  parameter int LOCK_MAX = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        core_req_valid,
  input  logic        core_req_lock,
  input  logic [1:0]  core_req_memo,
  input  logic [7:0]  core_req_mask,
  input  logic [63:0] core_req_addr,
  input  logic [63:0] core_req_data,
  output logic        core_req_ready,
  output logic        core_rsp_valid,
  output logic [63:0] core_rsp_data,
  output logic        core_rsp_exc,
  input  logic        dma_req_valid,
  input  logic        dma_req_lock,
  input  logic [1:0]  dma_req_memo,
  input  logic [7:0]  dma_req_mask,
  input  logic [63:0] dma_req_addr,
  input  logic [63:0] dma_req_data,
  output logic        dma_req_ready,
  output logic        dma_rsp_valid,
  output logic [63:0] dma_rsp_data,
  output logic        dma_rsp_exc,
  output logic        mem_enable,
  output logic [1:0]  mem_memo,
  output logic [7:0]  mem_mask,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_data,
  input  logic [63:0] mem_resp,
  input  logic        mem_exc
);

  // Owner encoding: 0 = core, 1 = dma
  localparam logic [2:0] LOCK_MAX_C = 3'(LOCK_MAX);

  logic       last_grant_q, last_grant_d;
  logic       lock_vld_q, lock_vld_d;
  logic       lock_own_q, lock_own_d;
  logic [2:0] lock_cnt_q, lock_cnt_d;

  logic        iss_vld_q, iss_own_q;
  logic [1:0]  iss_memo_q;
  logic [7:0]  iss_mask_q;
  logic [63:0] iss_addr_q, iss_data_q;

  logic        rsp_vld_q, rsp_own_q, rsp_exc_q;
  logic [63:0] rsp_data_q;

  logic gnt_core, gnt_dma, forced, accept, acc_own, acc_lock, own_valid;

  // Grant selection
  always_comb begin
    gnt_core = 1'b0;
    gnt_dma  = 1'b0;
    forced   = 1'b0;
    if (!RESET) begin
      if (core_req_valid && dma_req_valid) begin
        if (lock_vld_q) begin
          // Lock budget used up: hand the port to the waiting side
          if (lock_cnt_q == LOCK_MAX_C) begin
            forced   = 1'b1;
            gnt_core = lock_own_q;
            gnt_dma  = ~lock_own_q;
          end else begin
            gnt_core = ~lock_own_q;
            gnt_dma  = lock_own_q;
          end
        end else begin
          gnt_core = last_grant_q;
          gnt_dma  = ~last_grant_q;
        end
      end else begin
        gnt_core = core_req_valid;
        gnt_dma  = dma_req_valid;
      end
    end
  end

  assign accept    = gnt_core | gnt_dma;
  assign acc_own   = gnt_dma;
  assign acc_lock  = gnt_dma ? dma_req_lock : core_req_lock;
  assign own_valid = lock_own_q ? dma_req_valid : core_req_valid;

  // Lock / round-robin state update
  always_comb begin
    last_grant_d = last_grant_q;
    lock_vld_d   = lock_vld_q;
    lock_own_d   = lock_own_q;
    lock_cnt_d   = lock_cnt_q;
    if (accept) begin
      last_grant_d = acc_own;
      if (acc_lock && !forced) begin
        lock_vld_d = 1'b1;
        lock_own_d = acc_own;
        if (lock_vld_q && lock_own_q == acc_own)
          lock_cnt_d = (lock_cnt_q >= LOCK_MAX_C) ? LOCK_MAX_C : lock_cnt_q + 3'd1;
        else
          lock_cnt_d = 3'd1;
      end else begin
        lock_vld_d = 1'b0;
        lock_cnt_d = 3'd0;
      end
    end else if (lock_vld_q && !own_valid) begin
      // Owner dropped valid: release the lock
      lock_vld_d = 1'b0;
      lock_cnt_d = 3'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_grant_q <= 1'b1;
      lock_vld_q   <= 1'b0;
      lock_own_q   <= 1'b0;
      lock_cnt_q   <= 3'd0;
      iss_vld_q    <= 1'b0;
      iss_own_q    <= 1'b0;
      iss_memo_q   <= '0;
      iss_mask_q   <= '0;
      iss_addr_q   <= '0;
      iss_data_q   <= '0;
      rsp_vld_q    <= 1'b0;
      rsp_own_q    <= 1'b0;
      rsp_exc_q    <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      lock_vld_q   <= lock_vld_d;
      lock_own_q   <= lock_own_d;
      lock_cnt_q   <= lock_cnt_d;
      iss_vld_q    <= accept;
      if (accept) begin
        iss_own_q  <= acc_own;
        iss_memo_q <= acc_own ? dma_req_memo : core_req_memo;
        iss_mask_q <= acc_own ? dma_req_mask : core_req_mask;
        iss_addr_q <= acc_own ? dma_req_addr : core_req_addr;
        iss_data_q <= acc_own ? dma_req_data : core_req_data;
      end
      rsp_vld_q <= iss_vld_q;
      if (iss_vld_q) begin
        rsp_own_q  <= iss_own_q;
        rsp_data_q <= mem_resp;
        rsp_exc_q  <= mem_exc;
      end
    end
  end

  // Outputs are gated with RESET so everything reads 0 while it is held,
  // including the cycle in which it is first asserted.
  logic iss_on, rsp_on;
  assign iss_on = iss_vld_q & ~RESET;
  assign rsp_on = rsp_vld_q & ~RESET;

  assign core_req_ready = gnt_core;
  assign dma_req_ready  = gnt_dma;

  assign mem_enable = iss_on;
  assign mem_memo   = iss_on ? iss_memo_q : '0;
  assign mem_mask   = iss_on ? iss_mask_q : '0;
  assign mem_addr   = iss_on ? iss_addr_q : '0;
  assign mem_data   = iss_on ? iss_data_q : '0;

  assign core_rsp_valid = rsp_on & ~rsp_own_q;
  assign core_rsp_data  = core_rsp_valid ? rsp_data_q : '0;
  assign core_rsp_exc   = core_rsp_valid & rsp_exc_q;
  assign dma_rsp_valid  = rsp_on & rsp_own_q;
  assign dma_rsp_data   = dma_rsp_valid ? rsp_data_q : '0;
  assign dma_rsp_exc    = dma_rsp_valid & rsp_exc_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the RAM data port (memAction: op, mask, address, write data → response, data exception) between Core0 and a DMA/debug requester. It sits between the processor top and the RAM, taking the place of the direct Core0 → RAM data-port connection. Requests are granted round-robin with an optional bounded lock for back-to-back bursts, registered into an issue stage, and the RAM response is returned to the owning requester two cycles after acceptance.

## Interface
Parameters:
- LOCK_MAX, 4: maximum consecutive locked grants to one requester while the other is waiting.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- core_req_valid  in  1  Core0 has a request.
- core_req_lock  in  1  Core0 asks to keep the grant for its next request.
- core_req_memo / core_req_mask / core_req_addr / core_req_data  in  2/8/64/64  Core0 request fields.
- core_req_ready  out  1  Core0 request accepted this cycle (valid & ready).
- core_rsp_valid  out  1  one-cycle pulse: response for Core0.
- core_rsp_data  out  64  response data.
- core_rsp_exc  out  1  data exception for that request.
- dma_req_valid, dma_req_lock, dma_req_memo/mask/addr/data, dma_req_ready, dma_rsp_valid, dma_rsp_data, dma_rsp_exc: same as the core_* ports, for the DMA requester.
- mem_enable  out  1  drives the RAM data-port enable.
- mem_memo / mem_mask / mem_addr / mem_data  out  2/8/64/64  drive the RAM op, mask, address, write data.
- mem_resp  in  64  RAM response; combinational in the mem_enable cycle.
- mem_exc  in  1  RAM dException; combinational in the mem_enable cycle.

## Operation
- Arbitration (combinational, from current valids and state):
  - Exactly one of core_req_ready/dma_req_ready may be 1.
  - Only one valid: that requester is granted.
  - Both valid with lock active: the lock owner is granted, unless lock_cnt == LOCK_MAX, in which case the other requester is granted.
  - Both valid with no lock: the requester that is not last_grant is granted.
  - Neither valid: no grant.
- Acceptance: the granted requester's fields and an owner tag are loaded into the issue register. issue_valid is set for one cycle. The register is free every cycle, so a new request can be accepted every cycle.
- Issue stage:
  - When issue_valid = 1: mem_enable = 1 and the mem_* outputs are driven from the issue register.
  - mem_resp and mem_exc are captured, together with the owner tag, into the response register.
- Response stage: the owner's rsp_valid pulses for one cycle with rsp_data and rsp_exc. There is no response backpressure; requesters must accept the pulse.
- Lock state:
  - lock_owner and lock_cnt (3 bits) are updated on each accept.
  - Accept with lock = 1: lock_owner := acceptor. lock_cnt := lock_cnt + 1 if the acceptor is already lock_owner, else 1. lock_cnt saturates at LOCK_MAX.
  - Accept with lock = 0, or a forced switch: the lock is cleared and lock_cnt := 0.
  - The lock is also cleared when the lock owner has valid = 0 for a cycle.
- last_grant := acceptor on every accept.
- Fields pass through untouched. memo is not interpreted; every accepted request, including a store, produces exactly one response.

## Timing
- Accept in cycle N (valid & ready high at edge N) → mem_enable high in cycle N+1 → owner rsp_valid high in cycle N+2.
- Fixed latency of 2 cycles. Throughput is one request per cycle. Responses return in acceptance order.
- Reset values:
  - All outputs are 0 (both readies are 0 during RESET).
  - issue_valid = 0, response-register valid = 0.
  - last_grant = DMA, so the first tie goes to Core0.
  - Lock cleared, lock_cnt = 0.
- RESET asserted mid-operation: in-flight issue and response entries are dropped. No mem_enable and no rsp_valid appear in the cycle after RESET deasserts.
- Simultaneous requests from both sides on the same cycle: only the granted side sees ready. The losing side must hold valid and its fields stable until ready.

## Test plan
- Single core request: core load at addr 0x1000, mask 0xFF; RAM returns 0xDEADBEEF_00000001 → mem_enable at N+1 with addr 0x1000; core_rsp_valid at N+2 with that data and exc = 0; dma_rsp_valid stays 0.
- Tie after reset: both valid continuously, no lock → grants alternate core, dma, core, dma. Each rsp_valid arrives 2 cycles after the matching grant. mem_enable stays high every cycle.
- Lock bound: core valid with lock = 1 continuously, DMA valid from cycle 0 → core granted 4 consecutive times (LOCK_MAX), then DMA granted, then core again.
- Exception routing: DMA store to addr 0xFFFF_FFFF_FFFF_FFF8 with mem_exc = 1 in the issue cycle → dma_rsp_exc = 1 with dma_rsp_valid at N+2; core sees nothing.
- Reset mid-flight: accept a core request at N, assert RESET at N+1 → no core_rsp_valid afterward; all outputs are 0 during reset; first tie after release goes to core.
- Back-to-back same requester: core issues 3 requests in cycles 0–2 with the DMA idle → ready = 1 each cycle; responses in cycles 2–4 carry data in request order.
